// File: rtl/conv_bram_mc.sv
// Multi-channel strided valid 2-D convolution over a BRAM read port.
// One sequential MAC per window; results are shifted, optionally ReLU'd,
// saturated and written to a BRAM write port one word per window.
module conv_bram_mc #(
  parameter int AXI_ADDR_BW = 10,
  parameter int AXI_DATA_BW = 32,
  parameter int DATA_BW     = 8,
  parameter int WEIGHT_BW   = 8,
  parameter int SUM_BW      = 24,
  parameter int OUT_BW      = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int STRIDE      = 1,
  parameter int NUM_CH      = 2,
  parameter int WEIGHT_BASE = 0,
  parameter int IMAGE_BASE  = 64,
  parameter int OUT_BASE    = 0
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   i_start,
  input  logic                   i_relu,
  input  logic [4:0]             i_shift,
  input  logic [AXI_DATA_BW-1:0] i_r_data,
  output logic [AXI_ADDR_BW-1:0] o_r_addr,
  output logic                   o_r_en,
  output logic [AXI_DATA_BW-1:0] o_w_data,
  output logic [AXI_ADDR_BW-1:0] o_w_addr,
  output logic                   o_w_en,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int OUT    = (DATA_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int IDX_BW = $clog2(KK + 1);
  localparam int KI_BW  = (KK > 1) ? $clog2(KK) : 1;
  localparam int K_BW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int O_BW   = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int C_BW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LOW_BW = (DATA_BW > WEIGHT_BW) ? DATA_BW : WEIGHT_BW;

  localparam logic signed [SUM_BW-1:0] SAT_MAX = SUM_BW'(2 ** (OUT_BW - 1) - 1);
  localparam logic signed [SUM_BW-1:0] SAT_MIN = SUM_BW'(-(2 ** (OUT_BW - 1)));

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_MAC    = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]               state;
  logic [IDX_BW-1:0]        idx;
  logic [IDX_BW-1:0]        rd_idx;
  logic                     rd_pend;
  logic [K_BW-1:0]          kx, ky, kx_n, ky_n;
  logic [O_BW-1:0]          ox, oy;
  logic [C_BW-1:0]          c;
  logic signed [SUM_BW-1:0] acc, acc_sum, prod;
  logic signed [DATA_BW-1:0]   pix;
  logic signed [WEIGHT_BW-1:0] wgt;
  logic signed [WEIGHT_BW-1:0] kernel [KK];
  logic                     relu_q;
  logic [4:0]               shift_q;
  logic                     unused_hi;

  function automatic logic [AXI_ADDR_BW-1:0] win_addr(input int unsigned y, input int unsigned x,
                                                      input int unsigned ky_i, input int unsigned kx_i);
    return AXI_ADDR_BW'(IMAGE_BASE + (y * STRIDE + ky_i) * DATA_SIZE + x * STRIDE + kx_i);
  endfunction

  function automatic logic [AXI_DATA_BW-1:0] post(input logic signed [SUM_BW-1:0] a,
                                                  input logic [4:0] sh, input logic rl);
    logic signed [SUM_BW-1:0] r;
    logic signed [OUT_BW-1:0] n;
    r = a >>> sh;
    if (rl && r[SUM_BW-1]) r = '0;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    n = r[OUT_BW-1:0];
    return AXI_DATA_BW'(n);
  endfunction

  // Product of the returning pixel with the weight of the read that fetched it.
  always_comb begin
    pix       = i_r_data[DATA_BW-1:0];
    wgt       = kernel[KI_BW'(rd_idx)];
    prod      = SUM_BW'(pix) * SUM_BW'(wgt);
    acc_sum   = acc + prod;
    unused_hi = ^i_r_data[AXI_DATA_BW-1:LOW_BW];
  end

  // Next kernel position, kx fastest.
  always_comb begin
    kx_n = kx + K_BW'(1);
    ky_n = ky;
    if (kx == K_BW'(KERNEL_SIZE - 1)) begin
      kx_n = '0;
      ky_n = ky + K_BW'(1);
    end
  end

  // Kernel registers capture the weight word one cycle after its read.
  always_ff @(posedge ACLK) begin
    if (state == S_LOAD_W && rd_pend)
      kernel[KI_BW'(rd_idx)] <= i_r_data[WEIGHT_BW-1:0];
  end

  // Control FSM; outputs are registered and set one edge ahead of their cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_IDLE;
      idx      <= '0;
      rd_idx   <= '0;
      rd_pend  <= 1'b0;
      kx       <= '0;
      ky       <= '0;
      ox       <= '0;
      oy       <= '0;
      c        <= '0;
      acc      <= '0;
      relu_q   <= 1'b0;
      shift_q  <= '0;
      o_r_addr <= '0;
      o_r_en   <= 1'b0;
      o_w_data <= '0;
      o_w_addr <= '0;
      o_w_en   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      rd_pend <= o_r_en;
      rd_idx  <= idx;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            relu_q   <= i_relu;
            shift_q  <= i_shift;
            c        <= '0;
            ox       <= '0;
            oy       <= '0;
            idx      <= '0;
            o_r_en   <= 1'b1;
            o_r_addr <= AXI_ADDR_BW'(WEIGHT_BASE);
            o_busy   <= 1'b1;
            state    <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (idx < IDX_BW'(KK - 1)) begin
            idx      <= idx + IDX_BW'(1);
            o_r_addr <= o_r_addr + AXI_ADDR_BW'(1);
          end else if (idx == IDX_BW'(KK - 1)) begin
            idx    <= IDX_BW'(KK);
            o_r_en <= 1'b0;
          end else begin
            idx      <= '0;
            kx       <= '0;
            ky       <= '0;
            o_r_en   <= 1'b1;
            o_r_addr <= win_addr(32'(oy), 32'(ox), 0, 0);
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          // The last product is folded into the write data on the same edge
          // the accumulator absorbs it, so WRITE needs no extra cycle.
          if (o_r_en && idx == '0) acc <= '0;
          else if (rd_pend) acc <= acc_sum;
          if (idx < IDX_BW'(KK - 1)) begin
            idx      <= idx + IDX_BW'(1);
            kx       <= kx_n;
            ky       <= ky_n;
            o_r_addr <= win_addr(32'(oy), 32'(ox), 32'(ky_n), 32'(kx_n));
          end else if (idx == IDX_BW'(KK - 1)) begin
            idx    <= IDX_BW'(KK);
            o_r_en <= 1'b0;
          end else begin
            o_w_en   <= 1'b1;
            o_w_addr <= AXI_ADDR_BW'(OUT_BASE + 32'(c) * OUT * OUT + 32'(oy) * OUT + 32'(ox));
            o_w_data <= post(acc_sum, shift_q, relu_q);
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          o_w_en <= 1'b0;
          idx    <= '0;
          kx     <= '0;
          ky     <= '0;
          o_r_en <= 1'b1;
          if (ox < O_BW'(OUT - 1)) begin
            ox       <= ox + O_BW'(1);
            o_r_addr <= win_addr(32'(oy), 32'(ox) + 1, 0, 0);
            state    <= S_MAC;
          end else if (oy < O_BW'(OUT - 1)) begin
            ox       <= '0;
            oy       <= oy + O_BW'(1);
            o_r_addr <= win_addr(32'(oy) + 1, 0, 0, 0);
            state    <= S_MAC;
          end else if (c < C_BW'(NUM_CH - 1)) begin
            ox       <= '0;
            oy       <= '0;
            c        <= c + C_BW'(1);
            o_r_addr <= AXI_ADDR_BW'(WEIGHT_BASE + (32'(c) + 1) * KK);
            state    <= S_LOAD_W;
          end else begin
            o_r_en <= 1'b0;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bram_mc.sv
// Randomized self-checking bench for conv_bram_mc with a BRAM model and an
// arithmetic reference model of the convolution.
module tb_conv_bram_mc;

  logic        clk = 1'b0;
  logic        rst, start, start2, relu;
  logic [4:0]  shift;
  logic [31:0] rdata, rdata2;
  logic [9:0]  r_addr, w_addr, r_addr2, w_addr2;
  logic [31:0] w_data, w_data2;
  logic        r_en, w_en, busy, done;
  logic        r_en2, w_en2, busy2, done2;

  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_rd = -1;
  int done_cnt = 0;
  int done_cyc = 0;
  int done2_cnt = 0;
  int overlap = 0;
  logic [9:0]  wa[$], wa2[$], ra2[$];
  logic [31:0] wd[$], wd2[$];
  int          wc[$];

  conv_bram_mc dut (
    .ACLK(clk), .ARESET(rst), .i_start(start), .i_relu(relu), .i_shift(shift),
    .i_r_data(rdata), .o_r_addr(r_addr), .o_r_en(r_en), .o_w_data(w_data),
    .o_w_addr(w_addr), .o_w_en(w_en), .o_busy(busy), .o_done(done)
  );

  conv_bram_mc #(.STRIDE(2)) dut_s2 (
    .ACLK(clk), .ARESET(rst), .i_start(start2), .i_relu(relu), .i_shift(shift),
    .i_r_data(rdata2), .o_r_addr(r_addr2), .o_r_en(r_en2), .o_w_data(w_data2),
    .o_w_addr(w_addr2), .o_w_en(w_en2), .o_busy(busy2), .o_done(done2)
  );

  always #5 clk = ~clk;

  // BRAM read port: data one cycle after the enable.
  always @(posedge clk) begin
    if (r_en)  rdata  <= mem[r_addr];
    if (r_en2) rdata2 <= mem[r_addr2];
  end

  // Observe outputs mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (r_en && first_rd < 0) first_rd = cyc;
    if (w_en) begin wa.push_back(w_addr); wd.push_back(w_data); wc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (r_en && w_en) overlap++;
    if (r_en2) ra2.push_back(r_addr2);
    if (w_en2) begin wa2.push_back(w_addr2); wd2.push_back(w_data2); end
    if (done2) done2_cnt++;
    if (r_en2 && w_en2) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int sx8(input logic [31:0] w);
    logic signed [7:0] b;
    b = w[7:0];
    return int'(b);
  endfunction

  // Reference: plain sum of products, wrapped to 24 bits, shift, ReLU, clamp.
  function automatic logic [31:0] ref_out(input int ch, input int oy, input int ox,
                                          input int st, input bit rl, input int sh);
    longint s;
    logic signed [23:0] a;
    int r;
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += longint'(sx8(mem[64 + (oy * st + ky) * 8 + ox * st + kx]) * sx8(mem[ch * 9 + ky * 3 + kx]));
    a = s[23:0];
    r = int'(a) >>> sh;
    if (rl && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return 32'(r);
  endfunction

  task automatic fill_img(input int kind, input logic [31:0] v);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        mem[64 + y * 8 + x] = (kind == 0) ? v : (kind == 1) ? 32'(x) : $urandom();
  endtask

  task automatic fill_w(input int ch, input int kind, input logic [31:0] v);
    for (int i = 0; i < 9; i++) mem[ch * 9 + i] = (kind == 0) ? v : $urandom();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_r_en"}, r_en, 0);
    check({tag, "_r_addr"}, r_addr, 0);
    check({tag, "_w_en"}, w_en, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_w_data"}, w_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run1(input bit rl, input logic [4:0] sh, input bit poke);
    int n;
    int bad;
    wa.delete(); wd.delete(); wc.delete();
    first_rd = -1;
    done_cnt = 0;
    @(negedge clk); relu = rl; shift = sh; start = 1'b1;
    @(negedge clk); start = 1'b0; relu = !rl; shift = ~sh;
    check("busy_on", busy, 1);
    if (poke) begin
      repeat (300) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 4000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("n_writes", wa.size(), 72);
    bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      check($sformatf("w_addr%0d", i), wa[i], i);
      check($sformatf("w_data%0d", i), wd[i], ref_out(i / 36, (i % 36) / 6, i % 6, 1, rl, int'(sh)));
      if (i > 0 && wc[i] - wc[i - 1] != ((i == 36) ? 21 : 11)) bad++;
    end
    check("spacing", bad, 0);
    if (wa.size() > 0) begin
      check("lat_first", wc[0] - first_rd, 20);
      check("done_lat", done_cyc - wc[wa.size() - 1], 1);
    end
    check("busy_off", busy, 0);
    check("rw_overlap", overlap, 0);
  endtask

  task automatic run2(input bit rl, input logic [4:0] sh);
    int n;
    wa2.delete(); wd2.delete(); ra2.delete();
    done2_cnt = 0;
    @(negedge clk); relu = rl; shift = sh; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    n = 0;
    while (done2_cnt == 0 && n < 2000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("s2_done", done2_cnt, 1);
    check("s2_writes", wa2.size(), 18);
    for (int i = 0; i < wa2.size(); i++) begin
      check($sformatf("s2_addr%0d", i), wa2[i], i);
      check($sformatf("s2_data%0d", i), wd2[i], ref_out(i / 9, (i % 9) / 3, i % 3, 2, rl, int'(sh)));
    end
    check("s2_win11", (ra2.size() > 45) ? ra2[45] : 10'd0, 82);
  endtask

  initial begin
    int nw;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; relu = 1'b0; shift = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    fill_img(0, 32'd1); fill_w(0, 0, 32'd1); fill_w(1, 0, 32'd1);
    run1(1'b0, 5'd0, 1'b0);
    check("ones_w0", (wd.size() > 0) ? wd[0] : 32'd0, 32'd9);

    fill_img(1, 32'd0); fill_w(0, 0, 32'd1); fill_w(1, 0, 32'hFFFF_FFFF);
    run1(1'b0, 5'd0, 1'b0);
    check("ramp_a36", (wd.size() > 36) ? wd[36] : 32'd0, 32'hFFFF_FFF7);
    run1(1'b1, 5'd0, 1'b1);

    fill_img(0, 32'd127); fill_w(0, 0, 32'd127); fill_w(1, 0, 32'd127);
    run1(1'b0, 5'd0, 1'b0);
    fill_w(0, 0, 32'hFFFF_FF80); fill_w(1, 0, 32'hFFFF_FF80);
    run1(1'b0, 5'd0, 1'b0);
    check("neg_sat", (wd.size() > 0) ? wd[0] : 32'd0, 32'hFFFF_FF80);

    for (int t = 0; t < 3; t++) begin
      fill_img(2, 32'd0); fill_w(0, 2, 32'd0); fill_w(1, 2, 32'd0);
      run1(1'($urandom_range(0, 1)), 5'($urandom_range(0, 12)), 1'b0);
    end

    fill_img(2, 32'd0); fill_w(0, 2, 32'd0); fill_w(1, 2, 32'd0);
    run2(1'($urandom_range(0, 1)), 5'($urandom_range(0, 10)));

    // Reset in the middle of channel 0.
    wa.delete(); wd.delete(); wc.delete();
    @(negedge clk); start = 1'b1; relu = 1'b0; shift = 5'd0;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    nw = wa.size();
    check("pre_rst_writes", nw, 2);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    repeat (500) @(negedge clk);
    check("post_rst_writes", wa.size(), nw);
    run1(1'($urandom_range(0, 1)), 5'($urandom_range(0, 12)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
